// File: rtl/mem_bus_ctrl_if.sv
// ============================================================================
// Module  : mem_bus_ctrl_if
// Brief   : Core-side read/write bus between the CPU and mem_bus_ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_bus_ctrl_if;
  logic        rd_en;
  logic [15:0] addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [31:0] wr_data;

  modport master (
    output rd_en, addr, wr_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, addr, wr_en, wr_data,
    output rd_data, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module  : mem_bus_ctrl
// Brief   : Single-port slave serving register file, RAM, UART TX and LEDs.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl #(
  parameter int    RAM_WORDS = 1024,
  parameter string INIT_FILE = "",
  parameter int    CLK_DIV   = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  mem_bus_ctrl_if.slave bus,
  output logic       uart_tx,
  output logic [7:0] leds,
  output logic       bus_err
);

  localparam int c_RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int c_CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

  localparam logic [13:0] c_W_RAM_BASE = 14'h0020;
  localparam logic [13:0] c_W_UDATA    = 14'h3C00;
  localparam logic [13:0] c_W_USTAT    = 14'h3C01;
  localparam logic [13:0] c_W_LED      = 14'h3C02;

  localparam logic [2:0] c_RG_REG   = 3'd0;
  localparam logic [2:0] c_RG_RAM   = 3'd1;
  localparam logic [2:0] c_RG_UDATA = 3'd2;
  localparam logic [2:0] c_RG_USTAT = 3'd3;
  localparam logic [2:0] c_RG_LED   = 3'd4;
  localparam logic [2:0] c_RG_BAD   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_RD_ACCESS  = 2'd1,
    S_RD_DONE    = 2'd2,
    S_RD_RELEASE = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  rd_state_t          r_state;
  logic [13:0]        r_rd_word;
  logic [2:0]         r_rd_region;
  logic [31:0]        r_mux_q;
  logic [31:0]        r_rd_data;
  logic               r_rd_valid;
  logic               r_overrun;

  tx_state_t          r_tx_state;
  logic [c_CNT_W-1:0] r_tx_cnt;
  logic [2:0]         r_tx_bit;
  logic [7:0]         r_tx_shift;

  logic [31:0]        r_ram [RAM_WORDS];
  logic [31:0]        r_rf  [32];
  logic [31:0]        r_ram_q;
  logic [31:0]        r_rf_q;

  logic [13:0]         w_word;
  logic [13:0]         w_ram_off;
  logic [c_RAM_AW-1:0] w_ram_idx;
  logic [4:0]          w_rf_idx;
  logic [2:0]          w_region;
  logic                w_rd_issue;
  logic                w_wr_uart;
  logic                w_tx_ready;
  logic                w_tx_accept;
  logic                w_tx_busy;
  logic                w_status_rd;
  logic                w_fwd;
  logic [31:0]         w_rd_mux;

  assign w_word    = 14'(bus.addr >> 2);
  assign w_ram_off = w_word - c_W_RAM_BASE;
  assign w_ram_idx = w_ram_off[c_RAM_AW-1:0];
  assign w_rf_idx  = w_word[4:0];

  always_comb begin
    w_region = c_RG_BAD;
    if (w_word < c_W_RAM_BASE)
      w_region = c_RG_REG;
    else if (w_word == c_W_UDATA)
      w_region = c_RG_UDATA;
    else if (w_word == c_W_USTAT)
      w_region = c_RG_USTAT;
    else if (w_word == c_W_LED)
      w_region = c_RG_LED;
    else if (32'(w_ram_off) < RAM_WORDS)
      w_region = c_RG_RAM;
  end

  // A simultaneous write takes the bus; the read is picked up the cycle after.
  assign w_rd_issue  = (r_state == S_IDLE) && bus.rd_en && !bus.wr_en;
  assign w_wr_uart   = bus.wr_en && (w_region == c_RG_UDATA);
  assign w_tx_ready  = (r_tx_state == TX_IDLE) ||
                       ((r_tx_state == TX_STOP) && (r_tx_cnt == c_CNT_LAST));
  assign w_tx_accept = w_wr_uart && w_tx_ready;
  assign w_tx_busy   = (r_tx_state != TX_IDLE);
  assign w_status_rd = (r_state == S_RD_ACCESS) && (r_rd_region == c_RG_USTAT);

  // A write landing on the word being read during RD_ACCESS overtakes the stale array output.
  assign w_fwd = bus.wr_en && (w_word == r_rd_word) &&
                 ((r_rd_region == c_RG_RAM) ||
                  ((r_rd_region == c_RG_REG) && (r_rd_word[4:0] != 5'd0)));

  always_comb begin
    w_rd_mux = '0;
    case (r_rd_region)
      c_RG_REG:   if (r_rd_word[4:0] != 5'd0) w_rd_mux = r_rf_q;
      c_RG_RAM:   w_rd_mux = r_ram_q;
      c_RG_USTAT: w_rd_mux = {30'b0, r_overrun, w_tx_busy};
      c_RG_LED:   w_rd_mux = {24'b0, leds};
      default:    w_rd_mux = '0;
    endcase
    if (w_fwd)
      w_rd_mux = bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && (w_region == c_RG_RAM))
      r_ram[w_ram_idx] <= bus.wr_data;
    if (w_rd_issue)
      r_ram_q <= r_ram[w_ram_idx];
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && (w_region == c_RG_REG) && (w_rf_idx != 5'd0))
      r_rf[w_rf_idx] <= bus.wr_data;
    if (w_rd_issue)
      r_rf_q <= r_rf[w_rf_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rd_word   <= '0;
      r_rd_region <= c_RG_BAD;
      r_mux_q     <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rd_issue) begin
            r_rd_word   <= w_word;
            r_rd_region <= w_region;
            r_state     <= S_RD_ACCESS;
          end
        end
        S_RD_ACCESS: begin
          r_mux_q <= w_rd_mux;
          r_state <= S_RD_DONE;
        end
        S_RD_DONE: begin
          r_rd_data  <= r_mux_q;
          r_rd_valid <= 1'b1;
          r_state    <= S_RD_RELEASE;
        end
        S_RD_RELEASE: begin
          // Holding rd_en must not retrigger the same request.
          if (!bus.rd_en)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds      <= '0;
      bus_err   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (bus.wr_en && (w_region == c_RG_LED))
        leds <= bus.wr_data[7:0];
      if ((bus.wr_en || w_rd_issue) && (w_region == c_RG_BAD))
        bus_err <= 1'b1;
      if (w_wr_uart && !w_tx_ready)
        r_overrun <= 1'b1;
      else if (w_status_rd)
        r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      uart_tx    <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_accept) begin
            r_tx_state <= TX_START;
            r_tx_cnt   <= '0;
            r_tx_shift <= bus.wr_data[7:0];
            uart_tx    <= 1'b0;
          end
        end
        TX_START: begin
          if (r_tx_cnt == c_CNT_LAST) begin
            r_tx_state <= TX_DATA;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            uart_tx    <= r_tx_shift[0];
          end else begin
            r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == c_CNT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= TX_STOP;
              uart_tx    <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              uart_tx    <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == c_CNT_LAST) begin
            r_tx_cnt <= '0;
            if (w_tx_accept) begin
              r_tx_state <= TX_START;
              r_tx_shift <= bus.wr_data[7:0];
              uart_tx    <= 1'b0;
            end else begin
              r_tx_state <= TX_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + c_CNT_W'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
// ============================================================================
// Module  : tb_mem_bus_ctrl
// Brief   : Directed plus randomized self-checking bench for mem_bus_ctrl.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_ctrl;

  localparam int RW  = 64;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_tx;
  logic [7:0] leds;
  logic       bus_err;

  mem_bus_ctrl_if bus ();

  mem_bus_ctrl #(
    .RAM_WORDS (RW),
    .INIT_FILE (""),
    .CLK_DIV   (DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .uart_tx (uart_tx),
    .leds    (leds),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model [int];
  logic [7:0]  exp_leds = 8'h00;
  logic        exp_err  = 1'b0;
  int          wq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: word-indexed memory image, x0 hard-wired to zero, map by plain arithmetic.
  function automatic void model_write(input logic [15:0] a, input logic [31:0] d);
    int w;
    w = int'(a) / 4;
    if (w >= 1 && w < 32 + RW) model[w] = d;
    else if (w == 'hF008 / 4)  exp_leds = d[7:0];
    else if (w != 0 && w != 'hF000 / 4) exp_err = 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    if (w == 0) return 32'h0;
    return model[w];
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    model_write(a, d);
  endtask

  task automatic do_read(input logic [15:0] a, input int hold,
                         output logic [31:0] d, output int lat, output int extra);
    lat = 0; extra = 0;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.addr = a;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.rd_valid) break;
    end
    d = bus.rd_data;
    repeat (hold) begin
      @(negedge clk);
      if (bus.rd_valid) extra++;
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    if (bus.rd_valid) extra++;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d; int lat; int extra;
    do_read(a, 0, d, lat, extra);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check(tag, d, exp);
  endtask

  task automatic uart_run(input logic [7:0] b0, input bit overlap, input bit chain,
                          input logic [7:0] b1);
    logic q [$];
    logic [7:0] bytes [2];
    int nf;
    bytes[0] = b0; bytes[1] = b1;
    nf = chain ? 2 : 1;
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < 10; k++)
        repeat (DIV) q.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : bytes[f][k-1]);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.addr = 16'hF000; bus.wr_data = {24'h0, b0};
    @(negedge clk);
    for (int i = 0; i < q.size(); i++) begin
      check($sformatf("uart_tx[%0d]", i), {31'b0, uart_tx}, {31'b0, q[i]});
      if (i == 0 && overlap) begin
        bus.wr_en = 1'b1; bus.wr_data = {24'h0, b0 + 8'd1};
      end else if (chain && i == 10 * DIV - 1) begin
        bus.wr_en = 1'b1; bus.wr_data = {24'h0, b1};
      end else begin
        bus.wr_en = 1'b0;
      end
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    check("uart_idle_after", {31'b0, uart_tx}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] r;
    int lat, extra, w, pulses;
    logic [15:0] a;

    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_leds", {24'b0, leds}, 32'd0);
    check("rst_bus_err", {31'b0, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Held request: exactly one pulse, three cycles after rd_en rises.
    do_write(16'h0084, 32'h12345678);
    do_read(16'h0084, 4, d, lat, extra);
    check("held_data", d, model_read(16'h0084 / 4));
    check("held_lat", 32'(lat), 32'd3);
    check("held_extra_pulses", 32'(extra), 32'd0);

    do_write(16'h0000, 32'hFFFFFFFF);
    read_check("x0_read", 16'h0000, model_read(0));
    do_write(16'h0004, 32'h000000A5);
    read_check("x1_read", 16'h0004, model_read(1));

    // Write and read in the same IDLE cycle: write wins, read follows one cycle later.
    r = $urandom;
    @(negedge clk);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = 16'h0090; bus.wr_data = r;
    model_write(16'h0090, r);
    @(negedge clk);
    bus.wr_en = 1'b0;
    lat = 1;
    while (!bus.rd_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("rdwr_lat", 32'(lat), 32'd4);
    check("rdwr_data", bus.rd_data, model_read(16'h0090 / 4));
    bus.rd_en = 1'b0;
    @(negedge clk);

    wq.push_back(16'h0084 / 4);
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0) w = $urandom_range(0, 31);
      else                           w = $urandom_range(32, 32 + RW - 1);
      a = 16'(w * 4 + $urandom_range(0, 3));
      do_write(a, $urandom);
      if (w != 0) wq.push_back(w);
      read_check($sformatf("rand_raw_w%0d", w), a, model_read(w));
      w = wq[$urandom_range(0, wq.size() - 1)];
      read_check($sformatf("rand_old_w%0d", w), 16'(w * 4), model_read(w));
    end
    check("no_err_in_map", {31'b0, bus_err}, {31'b0, exp_err});

    a = 16'(16'h0080 + 4 * RW - 4);
    do_write(a, 32'hCAFEF00D);
    read_check("ram_last_word", a, model_read(int'(a) / 4));
    check("ram_last_no_err", {31'b0, bus_err}, 32'd0);
    read_check("ram_past_end", 16'(16'h0080 + 4 * RW), 32'd0);
    exp_err = 1'b1;
    check("ram_past_end_err", {31'b0, bus_err}, {31'b0, exp_err});
    read_check("unmapped_8000", 16'h8000, 32'd0);
    check("unmapped_err_sticky", {31'b0, bus_err}, {31'b0, exp_err});

    do_write(16'hF008, 32'h0000003C);
    check("leds_next_cycle", {24'b0, leds}, {24'b0, exp_leds});
    read_check("leds_read", 16'hF008, {24'b0, exp_leds});
    read_check("uart_data_read", 16'hF000, 32'd0);

    uart_run(8'h55, 1'b0, 1'b0, 8'h00);
    read_check("status_idle", 16'hF004, 32'd0);
    do_write(16'hF000, 32'h000000AA);
    read_check("status_busy", 16'hF004, 32'd1);
    repeat (12 * DIV) @(negedge clk);
    read_check("status_done", 16'hF004, 32'd0);

    uart_run(8'h41, 1'b1, 1'b0, 8'h00);
    read_check("status_overrun", 16'hF004, 32'd2);
    read_check("status_overrun_cleared", 16'hF004, 32'd0);

    uart_run(8'($urandom), 1'b0, 1'b1, 8'($urandom));
    read_check("status_after_chain", 16'hF004, 32'd0);

    // Asynchronous reset in the middle of a frame and a read.
    do_write(16'hF008, 32'h000000C3);
    check("leds_before_rst", {24'b0, leds}, {24'b0, exp_leds});
    do_write(16'hF000, 32'h00000000);
    repeat (2 * DIV) @(negedge clk);
    check("uart_low_before_rst", {31'b0, uart_tx}, 32'd0);
    bus.rd_en = 1'b1; bus.addr = 16'h0084;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_leds = 8'h00; exp_err = 1'b0;
    check("arst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("arst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
    check("arst_leds", {24'b0, leds}, {24'b0, exp_leds});
    check("arst_bus_err", {31'b0, bus_err}, {31'b0, exp_err});
    bus.rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_valid) pulses++;
      if (!uart_tx) pulses++;
    end
    check("no_resp_after_rst", 32'(pulses), 32'd0);
    read_check("status_after_rst", 16'hF004, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
